// File: rtl/nrzi_unstuff_rx.sv
// -----------------------------------------------------------------------------
// nrzi_unstuff_rx
//
// Receive front end for the USB packet decoder. The differential line is
// sampled once per clk (one bit time per cycle). The block hunts for SYNC,
// NRZI-decodes the line, removes stuffed bits and detects EOP. Decoded packet
// bits are forwarded in line order as bitOut/bitOutAvail, followed by a done
// pulse on a clean EOP. Line, stuffing, framing and length faults produce a
// single error pulse.
//
// Ports
//   clk          in   clock, all logic on posedge
//   rst_b        in   asynchronous active-low reset
//   rxEn         in   receive enable; low aborts any packet and idles the block
//   dp, dm       in   D+ / D- line samples
//   bitOut       out  decoded, unstuffed packet bit
//   bitOutAvail  out  one-cycle strobe qualifying bitOut
//   done         out  one-cycle pulse: packet ended with a valid EOP
//   error        out  one-cycle pulse: stuff / SE1 / EOP / overflow fault
//
// All outputs are registered: the response to a sample is visible during the
// cycle following the clock edge that captured it.
// -----------------------------------------------------------------------------
module nrzi_unstuff_rx #(
    parameter int STUFF_LEN = 6,
    parameter int MAX_BITS  = 99
) (
    input  logic clk,
    input  logic rst_b,
    input  logic rxEn,
    input  logic dp,
    input  logic dm,
    output logic bitOut,
    output logic bitOutAvail,
    output logic done,
    output logic error
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_DATA,
        ST_EOP1,
        ST_EOP2,
        ST_ERR
    } state_t;

    localparam logic [2:0] STUFF_LEN_C = 3'(STUFF_LEN);
    localparam logic [6:0] MAX_BITS_C  = 7'(MAX_BITS);
    // SYNC is seven decoded 0s then a 1; the counter holds bits seen so far.
    localparam logic [2:0] SYNC_LAST   = 3'd7;
    // Line level is tracked as the dp value of the last J/K; J means dp=1.
    localparam logic       LEVEL_J     = 1'b1;

    state_t     state_q,      state_d;
    logic       prev_level_q, prev_level_d;
    logic [2:0] sync_cnt_q,   sync_cnt_d;
    logic [2:0] ones_cnt_q,   ones_cnt_d;
    logic [6:0] bit_cnt_q,    bit_cnt_d;
    logic       eop_ext_q,    eop_ext_d;   // the one tolerated extra SE0 has been used
    logic       last_se0_q,   last_se0_d;  // previous sample was SE0 (error recovery)

    logic       bit_out_q,    bit_out_d;
    logic       bit_avail_q,  bit_avail_d;
    logic       done_q,       done_d;
    logic       error_q,      error_d;

    // Line state decode
    logic line_j;
    logic line_k;
    logic line_se0;
    logic line_se1;
    logic line_jk;
    logic dec_bit;

    assign line_j   =  dp & ~dm;
    assign line_k   = ~dp &  dm;
    assign line_se0 = ~dp & ~dm;
    assign line_se1 =  dp &  dm;
    assign line_jk  = line_j | line_k;
    // NRZI: no transition decodes as 1. Only meaningful on J/K samples.
    assign dec_bit  = (dp == prev_level_q);

    // -------------------------------------------------------------------------
    // Next-state and output logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        prev_level_d = prev_level_q;
        sync_cnt_d   = sync_cnt_q;
        ones_cnt_d   = ones_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        eop_ext_d    = eop_ext_q;
        last_se0_d   = line_se0;
        bit_out_d    = 1'b0;
        bit_avail_d  = 1'b0;
        done_d       = 1'b0;
        error_d      = 1'b0;

        // The NRZI reference follows every J/K in every state, so decoding
        // stays aligned even while idling or discarding a bad packet.
        if (line_jk) begin
            prev_level_d = dp;
        end

        if (!rxEn) begin
            // We are driving the bus (or receive is off): drop everything
            // silently and restart from a clean J reference.
            state_d      = ST_IDLE;
            prev_level_d = LEVEL_J;
            sync_cnt_d   = '0;
            ones_cnt_d   = '0;
            bit_cnt_d    = '0;
            eop_ext_d    = 1'b0;
            last_se0_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // First K after J is the first SYNC bit (decoded 0).
                    if (line_k && (prev_level_q == LEVEL_J)) begin
                        state_d    = ST_SYNC;
                        sync_cnt_d = 3'd1;
                    end
                end

                ST_SYNC: begin
                    // Any deviation from KJKJKJKK just means this was not a
                    // packet; fall back without complaint.
                    if (!line_jk) begin
                        state_d = ST_IDLE;
                    end else if (sync_cnt_q != SYNC_LAST) begin
                        if (dec_bit) begin
                            state_d = ST_IDLE;
                        end else begin
                            sync_cnt_d = sync_cnt_q + 3'd1;
                        end
                    end else if (dec_bit) begin
                        // The trailing SYNC 1 already counts toward stuffing.
                        state_d    = ST_DATA;
                        ones_cnt_d = 3'd1;
                        bit_cnt_d  = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end

                ST_DATA: begin
                    if (line_jk) begin
                        if (ones_cnt_q == STUFF_LEN_C) begin
                            // This bit position is a stuff bit: must be 0, never forwarded.
                            ones_cnt_d = '0;
                            if (dec_bit) begin
                                error_d = 1'b1;
                                state_d = ST_ERR;
                            end
                        end else if (bit_cnt_q == MAX_BITS_C) begin
                            // Longer than the largest legal packet.
                            error_d = 1'b1;
                            state_d = ST_ERR;
                        end else begin
                            bit_out_d   = dec_bit;
                            bit_avail_d = 1'b1;
                            bit_cnt_d   = bit_cnt_q + 7'd1;
                            ones_cnt_d  = dec_bit ? (ones_cnt_q + 3'd1) : 3'd0;
                        end
                    end else if (line_se0) begin
                        state_d = ST_EOP1;
                    end else if (line_se1) begin
                        error_d = 1'b1;
                        state_d = ST_ERR;
                    end
                end

                ST_EOP1: begin
                    if (line_se0) begin
                        state_d   = ST_EOP2;
                        eop_ext_d = 1'b0;
                    end else begin
                        error_d = 1'b1;
                        state_d = ST_ERR;
                    end
                end

                ST_EOP2: begin
                    if (line_j) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else if (line_se0 && !eop_ext_q) begin
                        // A stretched EOP of three SE0 bit times is accepted once.
                        eop_ext_d = 1'b1;
                    end else begin
                        error_d = 1'b1;
                        state_d = ST_ERR;
                    end
                end

                ST_ERR: begin
                    // Resynchronise on the end of whatever is on the bus: an SE0
                    // immediately followed by J. No further pulses meanwhile.
                    if (line_j && last_se0_q) begin
                        state_d = ST_IDLE;
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q      <= ST_IDLE;
            prev_level_q <= LEVEL_J;
            sync_cnt_q   <= '0;
            ones_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            eop_ext_q    <= 1'b0;
            last_se0_q   <= 1'b0;
            bit_out_q    <= 1'b0;
            bit_avail_q  <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            prev_level_q <= prev_level_d;
            sync_cnt_q   <= sync_cnt_d;
            ones_cnt_q   <= ones_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            eop_ext_q    <= eop_ext_d;
            last_se0_q   <= last_se0_d;
            bit_out_q    <= bit_out_d;
            bit_avail_q  <= bit_avail_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    assign bitOut      = bit_out_q;
    assign bitOutAvail = bit_avail_q;
    assign done        = done_q;
    assign error       = error_q;

endmodule
